// File: rtl/matrix_row_buffer_pkg.sv
// Shared types and packing helpers for the matrix row buffer and its vector register.
package matrix_row_buffer_pkg;

  localparam int DEF_NUM_ROWS    = 3;
  localparam int DEF_NUM_COLS    = 3;
  localparam int DEF_SCALAR_BITS = 32;

  // One matrix element at the default width
  typedef logic [DEF_SCALAR_BITS-1:0] scalar_t;

  // LSB position of element idx inside a packed row or column vector
  function automatic int unsigned slot_lsb(input int unsigned idx, input int unsigned bits);
    return idx * bits;
  endfunction

  // True when an address refers to an existing row, column or slice
  function automatic bit idx_in_range(input int unsigned idx, input int unsigned limit);
    return idx < limit;
  endfunction

endpackage

// File: rtl/matrix_row_buffer_slice_vector_reg.sv
// Vector register with whole-vector load and per-element slice read/write.
module slice_vector_reg
  import matrix_row_buffer_pkg::*;
#(
  parameter int SCALAR_BITS = DEF_SCALAR_BITS,
  parameter int LENGTH      = DEF_NUM_COLS,
  localparam int IDX_BITS   = (LENGTH > 1) ? $clog2(LENGTH) : 1,
  localparam int VEC_BITS   = LENGTH * SCALAR_BITS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [VEC_BITS-1:0]    vec_in,
  input  logic                   write_slice,
  input  logic [IDX_BITS-1:0]    write_index,
  input  logic [SCALAR_BITS-1:0] slice_in,
  input  logic [IDX_BITS-1:0]    read_index,
  output logic [VEC_BITS-1:0]    vec_out,
  output logic [SCALAR_BITS-1:0] slice_out
);

  logic [SCALAR_BITS-1:0] v_q [LENGTH];
  logic [SCALAR_BITS-1:0] v_d [LENGTH];

  // Next vector: a full load takes priority over a single-slice write
  always_comb begin
    v_d = v_q;
    if (load) begin
      for (int i = 0; i < LENGTH; i++) begin
        v_d[i] = vec_in[slot_lsb(i, SCALAR_BITS) +: SCALAR_BITS];
      end
    end else if (write_slice && idx_in_range(32'(write_index), LENGTH)) begin
      v_d[write_index] = slice_in;
    end
  end

  // Vector storage, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '{default: '0};
    end else begin
      v_q <= v_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LENGTH; gi++) begin : g_pack
      assign vec_out[gi*SCALAR_BITS +: SCALAR_BITS] = v_q[gi];
    end
  endgenerate

  // Combinational slice read; out-of-range index reads zero
  always_comb begin
    slice_out = '0;
    if (idx_in_range(32'(read_index), LENGTH)) begin
      slice_out = v_q[read_index];
    end
  end

endmodule

// File: rtl/matrix_row_buffer.sv
// Flop-based matrix store with element write, registered row/column reads and a working row register.
module matrix_row_buffer
  import matrix_row_buffer_pkg::*;
#(
  parameter int NUM_ROWS    = DEF_NUM_ROWS,
  parameter int NUM_COLS    = DEF_NUM_COLS,
  parameter int SCALAR_BITS = DEF_SCALAR_BITS,
  localparam int RA         = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int CA         = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1,
  localparam int ROW_SIZE   = NUM_COLS * SCALAR_BITS,
  localparam int COL_SIZE   = NUM_ROWS * SCALAR_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [RA-1:0]          row_addr,
  input  logic                   row_addr_ready,
  output logic                   row_valid,
  output logic [ROW_SIZE-1:0]    row_out,
  input  logic [CA-1:0]          col_addr,
  input  logic                   col_addr_ready,
  output logic                   col_valid,
  output logic [COL_SIZE-1:0]    col_out,
  input  logic [RA-1:0]          write_row_addr,
  input  logic [CA-1:0]          write_col_addr,
  input  logic [SCALAR_BITS-1:0] write_data,
  input  logic                   write_ready,
  input  logic                   reg_load,
  output logic [ROW_SIZE-1:0]    reg_out,
  input  logic [CA-1:0]          reg_read_index,
  output logic [SCALAR_BITS-1:0] reg_slice_out,
  input  logic [CA-1:0]          reg_write_index,
  input  logic [SCALAR_BITS-1:0] reg_slice_in,
  input  logic                   reg_write_slice
);

  logic [SCALAR_BITS-1:0] m_q [NUM_ROWS][NUM_COLS];
  logic [SCALAR_BITS-1:0] m_d [NUM_ROWS][NUM_COLS];
  logic [ROW_SIZE-1:0]    row_out_q, row_out_d, row_sel;
  logic [COL_SIZE-1:0]    col_out_q, col_out_d, col_sel;
  logic                   row_valid_q, row_valid_d;
  logic                   col_valid_q, col_valid_d;

  // Element write; out-of-range addresses leave the matrix untouched
  always_comb begin
    m_d = m_q;
    if (write_ready && idx_in_range(32'(write_row_addr), NUM_ROWS)
                    && idx_in_range(32'(write_col_addr), NUM_COLS)) begin
      m_d[write_row_addr][write_col_addr] = write_data;
    end
  end

  // Row and column selection from the current (pre-write) matrix contents
  always_comb begin
    row_sel = '0;
    col_sel = '0;
    if (idx_in_range(32'(row_addr), NUM_ROWS)) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        row_sel[slot_lsb(c, SCALAR_BITS) +: SCALAR_BITS] = m_q[row_addr][c];
      end
    end
    if (idx_in_range(32'(col_addr), NUM_COLS)) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        col_sel[slot_lsb(r, SCALAR_BITS) +: SCALAR_BITS] = m_q[r][col_addr];
      end
    end
  end

  // Read ports capture on request and otherwise hold their last data
  always_comb begin
    row_valid_d = row_addr_ready;
    col_valid_d = col_addr_ready;
    row_out_d   = row_addr_ready ? row_sel : row_out_q;
    col_out_d   = col_addr_ready ? col_sel : col_out_q;
  end

  // Matrix and read-port registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q         <= '{default: '{default: '0}};
      row_out_q   <= '0;
      col_out_q   <= '0;
      row_valid_q <= 1'b0;
      col_valid_q <= 1'b0;
    end else begin
      m_q         <= m_d;
      row_out_q   <= row_out_d;
      col_out_q   <= col_out_d;
      row_valid_q <= row_valid_d;
      col_valid_q <= col_valid_d;
    end
  end

  assign row_out   = row_out_q;
  assign col_out   = col_out_q;
  assign row_valid = row_valid_q;
  assign col_valid = col_valid_q;

  // Working row register fed from the registered row output
  slice_vector_reg #(
    .SCALAR_BITS (SCALAR_BITS),
    .LENGTH      (NUM_COLS)
  ) u_vec_reg (
    .clk         (clk),
    .rst_n       (rst),
    .load        (reg_load),
    .vec_in      (row_out_q),
    .write_slice (reg_write_slice),
    .write_index (reg_write_index),
    .slice_in    (reg_slice_in),
    .read_index  (reg_read_index),
    .vec_out     (reg_out),
    .slice_out   (reg_slice_out)
  );

endmodule

// File: tb/tb_matrix_row_buffer.sv
// Directed scoreboard bench for matrix_row_buffer (3x3, 32-bit elements).
module tb_matrix_row_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  row_addr, col_addr, write_row_addr, write_col_addr;
  logic [1:0]  reg_read_index, reg_write_index;
  logic        row_addr_ready, col_addr_ready, write_ready;
  logic        reg_load, reg_write_slice;
  logic [31:0] write_data, reg_slice_in, reg_slice_out;
  logic        row_valid, col_valid;
  logic [95:0] row_out, col_out, reg_out;

  int passed = 0;
  int total  = 0;

  logic [31:0] mdl [3][3];
  logic [31:0] vmdl [3];
  logic [95:0] row_exp_q [$];
  logic [95:0] col_exp_q [$];

  always #5 clk = ~clk;

  matrix_row_buffer dut (
    .clk(clk), .rst(rst),
    .row_addr(row_addr), .row_addr_ready(row_addr_ready), .row_valid(row_valid), .row_out(row_out),
    .col_addr(col_addr), .col_addr_ready(col_addr_ready), .col_valid(col_valid), .col_out(col_out),
    .write_row_addr(write_row_addr), .write_col_addr(write_col_addr),
    .write_data(write_data), .write_ready(write_ready),
    .reg_load(reg_load), .reg_out(reg_out),
    .reg_read_index(reg_read_index), .reg_slice_out(reg_slice_out),
    .reg_write_index(reg_write_index), .reg_slice_in(reg_slice_in),
    .reg_write_slice(reg_write_slice)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
      $display("check %s observed=%h expected=%h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] model_row(input int r);
    logic [95:0] v = '0;
    if (r < 3) for (int c = 0; c < 3; c++) v[c*32 +: 32] = mdl[r][c];
    return v;
  endfunction

  function automatic logic [95:0] model_col(input int c);
    logic [95:0] v = '0;
    if (c < 3) for (int r = 0; r < 3; r++) v[r*32 +: 32] = mdl[r][c];
    return v;
  endfunction

  task automatic clear_model();
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) mdl[r][c] = '0;
  endtask

  // Pop the oldest expected row and compare against the DUT output
  task automatic pop_row(input string tag);
    check({tag, "_valid"}, 96'(row_valid), 96'(1));
    if (row_exp_q.size() == 0) begin
      total++;
      $error("FAIL %s observed=output expected=empty_scoreboard", tag);
    end else begin
      check(tag, row_out, row_exp_q.pop_front());
    end
  endtask

  task automatic pop_col(input string tag);
    check({tag, "_valid"}, 96'(col_valid), 96'(1));
    if (col_exp_q.size() == 0) begin
      total++;
      $error("FAIL %s observed=output expected=empty_scoreboard", tag);
    end else begin
      check(tag, col_out, col_exp_q.pop_front());
    end
  endtask

  task automatic check_slices(input string tag);
    for (int i = 0; i < 3; i++) begin
      reg_read_index = 2'(i);
      #1;
      check($sformatf("%s_slice%0d", tag, i), 96'(reg_slice_out), 96'(vmdl[i]));
    end
  endtask

  task automatic write_elem(input int r, input int c, input logic [31:0] d);
    write_row_addr = 2'(r);
    write_col_addr = 2'(c);
    write_data     = d;
    write_ready    = 1'b1;
    tick();
    write_ready    = 1'b0;
    if (r < 3 && c < 3) mdl[r][c] = d;
  endtask

  initial begin
    rst = 1'b0;
    row_addr = '0; col_addr = '0; write_row_addr = '0; write_col_addr = '0;
    reg_read_index = '0; reg_write_index = '0;
    row_addr_ready = 1'b0; col_addr_ready = 1'b0; write_ready = 1'b0;
    reg_load = 1'b0; reg_write_slice = 1'b0;
    write_data = '0; reg_slice_in = '0;
    clear_model();
    for (int i = 0; i < 3; i++) vmdl[i] = '0;

    // 1. reset held two cycles
    tick(); tick();
    check("rst_row_valid", 96'(row_valid), 96'(0));
    check("rst_col_valid", 96'(col_valid), 96'(0));
    check("rst_row_out", row_out, '0);
    check("rst_col_out", col_out, '0);
    check("rst_reg_out", reg_out, '0);
    rst = 1'b1;
    tick();

    // 2. fill matrix with c+3r and read column 1
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) write_elem(r, c, 32'(c + 3*r));
    col_addr = 2'd1; col_addr_ready = 1'b1;
    col_exp_q.push_back(model_col(1));
    tick();
    col_addr_ready = 1'b0;
    pop_col("col1");

    // 3. back-to-back row reads, then valid drops
    for (int r = 0; r < 3; r++) begin
      row_addr = 2'(r); row_addr_ready = 1'b1;
      row_exp_q.push_back(model_row(r));
      tick();
      pop_row($sformatf("row%0d", r));
    end
    row_addr_ready = 1'b0;
    tick();
    check("row_valid_drop", 96'(row_valid), 96'(0));

    // 4. load row 1 into the vector register
    row_addr = 2'd1; row_addr_ready = 1'b1;
    row_exp_q.push_back(model_row(1));
    tick();
    row_addr_ready = 1'b0;
    pop_row("row1_for_load");
    reg_load = 1'b1;
    tick();
    reg_load = 1'b0;
    for (int i = 0; i < 3; i++) vmdl[i] = mdl[1][i];
    check("reg_load", reg_out, model_row(1));
    check_slices("loaded");

    // 5. slice writes, then load beats slice write
    for (int c = 0; c < 3; c++) begin
      reg_write_index = 2'(c); reg_slice_in = 32'(c); reg_write_slice = 1'b1;
      tick();
      reg_write_slice = 1'b0;
      vmdl[c] = 32'(c);
      check_slices($sformatf("swr%0d", c));
    end
    reg_write_index = 2'd0; reg_slice_in = 32'hDEAD_BEEF;
    reg_write_slice = 1'b1; reg_load = 1'b1;
    tick();
    reg_write_slice = 1'b0; reg_load = 1'b0;
    check("load_wins", reg_out, model_row(1));
    reg_write_index = 2'd3; reg_slice_in = 32'h1234_5678; reg_write_slice = 1'b1;
    tick();
    reg_write_slice = 1'b0;
    check("slice_wr_oor", reg_out, model_row(1));
    reg_read_index = 2'd3;
    #1;
    check("slice_rd_oor", 96'(reg_slice_out), '0);

    // read-before-write on the same element
    row_addr = 2'd0; row_addr_ready = 1'b1;
    row_exp_q.push_back(model_row(0));
    write_elem(0, 0, 32'h0000_0055);
    row_addr_ready = 1'b0;
    pop_row("rbw_old");
    row_addr_ready = 1'b1;
    row_exp_q.push_back(model_row(0));
    tick();
    row_addr_ready = 1'b0;
    pop_row("rbw_new");

    // concurrent row and out-of-range column read
    row_addr = 2'd2; row_addr_ready = 1'b1;
    col_addr = 2'd3; col_addr_ready = 1'b1;
    row_exp_q.push_back(model_row(2));
    col_exp_q.push_back(96'(0));
    tick();
    row_addr_ready = 1'b0; col_addr_ready = 1'b0;
    pop_row("row2_dual");
    pop_col("col3_oor");

    // 6. asynchronous reset during an active row read
    row_addr = 2'd2; row_addr_ready = 1'b1;
    row_exp_q.push_back(model_row(2));
    tick();
    pop_row("pre_rst");
    #2;
    rst = 1'b0;
    #1;
    check("async_row_valid", 96'(row_valid), 96'(0));
    check("async_row_out", row_out, '0);
    check("async_reg_out", reg_out, '0);
    clear_model();
    for (int i = 0; i < 3; i++) vmdl[i] = '0;
    row_addr_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    row_addr = 2'd2; row_addr_ready = 1'b1;
    row_exp_q.push_back(model_row(2));
    tick();
    row_addr_ready = 1'b0;
    pop_row("post_rst_row2");
    write_elem(3, 0, 32'h0000_0099);
    row_addr = 2'd3; row_addr_ready = 1'b1;
    row_exp_q.push_back(96'(0));
    tick();
    pop_row("row3_oor");
    row_addr = 2'd0;
    row_exp_q.push_back(model_row(0));
    tick();
    row_addr_ready = 1'b0;
    pop_row("row0_after_oor_wr");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Hard bound so a stuck run still ends
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
